countdown_timer: RTL and testbench

Registered countdown stage built around the 4-bit decrement/borrow operation. It accepts a start value over a valid/ready handshake, decrements it once per enabled cycle, and emits a one-cycle `done` pulse when the decrement would borrow, i.e. when the count is already 0. It sits directly upstream of the combinational decrementer: it holds the operand in a register, feeds it to the decrement, and registers the result each cycle. It is the sequential timer wrapper the design uses for delays and timeouts.

---
 rtl/countdown_timer.sv | 83 ++++++++
 tb/tb_countdown_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable countdown timer with one-cycle done pulse and saturating expiry counter
// Build option COUNTDOWN_AUTO_RELOAD_EN: periodic mode, reloading the last start value on each expiry.
module countdown_timer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] expire_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic             borrow;
   logic [CNT_W-1:0] expire_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_value;
`endif

   assign load_ready  = (state == IDLE) && !abort;
   assign busy        = (state != IDLE);
   // Borrow of count - 1 ends the run instead of letting the register wrap.
   assign borrow      = (count == '0);
   assign expire_next = (expire_cnt == {CNT_W{1'b1}}) ? expire_cnt : expire_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         done       <= 1'b0;
         expire_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_value <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid && load_ready) begin
                  count <= load_value;
                  state <= RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  reload_value <= load_value;
`endif
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  count <= '0;
               end else if (enable) begin
                  if (!borrow) begin
                     count <= count - WIDTH'(1);
                  end else begin
                     done       <= 1'b1;
                     expire_cnt <= expire_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     count <= reload_value;
`else
                     state <= DONE;
`endif
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
// Table-driven runs with a done-pulse scoreboard, plus abort, reset and saturation sequences.
module tb_countdown_timer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             enable = 1'b0;
   logic             abort = 1'b0;
   logic             load_ready;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] expire_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int exp_expire = 0;

   typedef struct {
      int done_c;
      int expire;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int value;
      int pause_at;
      int pause_len;
      int done_c;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_value (load_value),
      .load_ready (load_ready),
      .enable     (enable),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .expire_cnt (expire_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Waits (bounded) for load_ready, then performs the handshake; returns 1ns after the accepting edge.
   task automatic do_load(input int v);
      int t;
      t = 0;
      while (!load_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("load_ready_before_load", load_ready, 1);
      load_valid = 1'b1;
      load_value = v[WIDTH-1:0];
      @(posedge clk);
      #1;
      load_valid = 1'b0;
   endtask

   task automatic pop_done(input int c);
      exp_t e;
      if (sb.size() == 0) begin
         check("unexpected_done", 1, 0);
      end else begin
         e = sb.pop_front();
         check("done_cycle", c, e.done_c);
         check("expire_at_done", int'(expire_cnt), e.expire);
      end
   endtask

   initial begin
      int pulses;
      int t;
      int seen;
      vecs[0] = '{5, -1, 0, 6};
      vecs[1] = '{0, -1, 0, 1};
      vecs[2] = '{15, -1, 0, 16};
      vecs[3] = '{3, 2, 4, 8};
      vecs[4] = '{9, 4, 2, 12};

      @(negedge clk);
      check("rst_count", int'(count), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_load_ready", load_ready, 1);
      check("rst_expire", int'(expire_cnt), 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      for (int i = 0; i < 5; i++) begin
         int exp_cnt;
         int pauses;
         int done_at;
         int saw15;
         bit finished;
         do_load(vecs[i].value);
         exp_expire = sat_inc(exp_expire);
         sb.push_back('{vecs[i].done_c, exp_expire});
         check("busy_after_load", busy, 1);
         check("ready_while_busy", load_ready, 0);
         check("count_after_load", int'(count), vecs[i].value);
         exp_cnt = vecs[i].value;
         pauses = vecs[i].pause_len;
         done_at = -1;
         saw15 = 0;
         finished = 1'b0;
         for (int c = 1; c <= 60; c++) begin
            if (pauses > 0 && exp_cnt == vecs[i].pause_at) begin
               enable = 1'b0;
               pauses--;
            end else begin
               enable = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (enable && exp_cnt != 0) exp_cnt--;
            if (count == 4'hF) saw15 = 1;
            if (done) begin
               done_at = c;
               pop_done(c);
            end else if (done_at < 0) begin
               check("count_trace", int'(count), exp_cnt);
            end
            if (done_at > 0 && c == done_at + 1) begin
               check("done_one_cycle", done, 0);
               check("idle_busy", busy, 0);
               check("idle_load_ready", load_ready, 1);
               finished = 1'b1;
               break;
            end
         end
         if (!finished) check("run_timeout", 1, 0);
         check("no_wrap_to_15", saw15, 0);
         enable = 1'b0;
      end

      // Abort mid-run: load 6, abort when count shows 2.
      do_load(6);
      enable = 1'b1;
      t = 0;
      while (count != 2 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("abort_reach_2", int'(count), 2);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_count", int'(count), 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_expire", int'(expire_cnt), exp_expire);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("abort_no_done", seen, 0);

      // Abort together with load_valid in IDLE blocks acceptance.
      abort = 1'b1;
      load_valid = 1'b1;
      load_value = 4'd7;
      #1;
      check("abort_idle_ready", load_ready, 0);
      @(posedge clk);
      #1;
      check("abort_idle_busy", busy, 0);
      abort = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-run at count 5.
      do_load(9);
      enable = 1'b1;
      t = 0;
      while (count != 5 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("reset_reach_5", int'(count), 5);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_count", int'(count), 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_load_ready", load_ready, 1);
      check("midrst_expire", int'(expire_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_expire = 0;

      // Back-to-back loads of 0 drive the expiry counter into saturation.
      load_value = '0;
      load_valid = 1'b1;
      pulses = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      load_valid = 1'b0;
      enable = 1'b0;
      check("sat_pulses_ge_256", int'(pulses >= 256), 1);
      check("sat_expire", int'(expire_cnt), 255);
`else
      // Periodic mode: load 2 gives count 2,1,0,2,... and done every third cycle.
      do_load(2);
      check("ar_count_after_load", int'(count), 2);
      for (int p = 1; p <= 4; p++) sb.push_back('{3 * p, p});
      enable = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         int exp_c;
         @(posedge clk);
         @(negedge clk);
         exp_c = (c % 3 == 0) ? 2 : 2 - (c % 3);
         check("ar_count", int'(count), exp_c);
         check("ar_ready", load_ready, 0);
         if (done) pop_done(c);
      end
      pulses = 4;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("ar_pulses_ge_256", int'(pulses >= 256), 1);
      check("ar_sat_expire", int'(expire_cnt), 255);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("ar_abort_busy", busy, 0);
      check("ar_abort_count", int'(count), 0);
`endif

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
